cpu_control_unit: RTL and testbench

- Moore FSM controller for the 8-bit accumulator datapath.
- Consumes the datapath status signals (IR opcode, Aeq0, Apos) and an operator Enter key.
- Produces every datapath control strobe: PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel.
- Sequences fetch/decode/execute for an 8-instruction ISA and reports halt and input-wait status.

---
 rtl/cpu_control_unit_pkg.sv | 51 +++++
 rtl/cpu_control_unit_if.sv | 35 +++
 rtl/cpu_control_unit_rise_detect.sv | 24 ++
 rtl/cpu_control_unit.sv | 103 ++++++++++
 tb/tb_cpu_control_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cpu_control_unit_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cpu_control_unit_pkg : opcodes, Asel codes and state encoding             |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package cpu_control_unit_pkg;

  localparam int OPC_W  = 3;
  localparam int ASEL_W = 2;

  localparam logic [OPC_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_STORE = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OPC_W-1:0] OP_IN    = 3'b100;
  localparam logic [OPC_W-1:0] OP_JZ    = 3'b101;
  localparam logic [OPC_W-1:0] OP_JPOS  = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT  = 3'b111;

  localparam logic [ASEL_W-1:0] ASEL_ALU = 2'b00;
  localparam logic [ASEL_W-1:0] ASEL_IN  = 2'b01;
  localparam logic [ASEL_W-1:0] ASEL_RAM = 2'b10;

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_STORE  = 4'd4;
  localparam logic [3:0] S_ADD    = 4'd5;
  localparam logic [3:0] S_SUB    = 4'd6;
  localparam logic [3:0] S_IN     = 4'd7;
  localparam logic [3:0] S_JZ     = 4'd8;
  localparam logic [3:0] S_JPOS   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  typedef enum logic [3:0] {
    ST_START  = S_START,
    ST_FETCH  = S_FETCH,
    ST_DECODE = S_DECODE,
    ST_LOAD   = S_LOAD,
    ST_STORE  = S_STORE,
    ST_ADD    = S_ADD,
    ST_SUB    = S_SUB,
    ST_IN     = S_IN,
    ST_JZ     = S_JZ,
    ST_JPOS   = S_JPOS,
    ST_HALT   = S_HALT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cpu_control_unit_if : datapath status and control strobes                 |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface cpu_control_unit_if;
  import cpu_control_unit_pkg::*;

  logic [OPC_W-1:0]  IR;
  logic              Aeq0;
  logic              Apos;
  logic              Enter;
  logic              PCload;
  logic              JMPmux;
  logic              IRload;
  logic              Meminst;
  logic              MemWr;
  logic              Aload;
  logic              Sub;
  logic [ASEL_W-1:0] Asel;
  logic              Halted;
  logic              InputReq;

  modport master (
    input  IR, Aeq0, Apos, Enter,
    output PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halted, InputReq
  );

  modport slave (
    output IR, Aeq0, Apos, Enter,
    input  PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halted, InputReq
  );

endinterface
`default_nettype wire

// File: rtl/cpu_control_unit_rise_detect.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rise_detect : 1-bit rising-edge detector, history resets high             |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Resetting high means a level already high at reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b1;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cpu_control_unit : fetch/decode/execute FSM for the accumulator datapath  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module cpu_control_unit
  import cpu_control_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  cpu_control_unit_if.master ctrl
);

  state_t            r_state;
  state_t            w_next;
  logic              w_enter_rise;
  logic              w_in_accept;
  logic              w_take_jump;
  logic              r_pc_load;
  logic              r_ir_load;
  logic              r_mem_inst;
  logic              r_mem_wr;
  logic              r_a_load;
  logic              r_sub;
  logic [ASEL_W-1:0] r_asel;
  logic              r_halted;
  logic              r_input_req;

  rise_detect u_enter_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (ctrl.Enter),
    .o_rise (w_enter_rise)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_START:  w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        unique case (ctrl.IR)
          OP_LOAD:  w_next = ST_LOAD;
          OP_STORE: w_next = ST_STORE;
          OP_ADD:   w_next = ST_ADD;
          OP_SUB:   w_next = ST_SUB;
          OP_IN:    w_next = ST_IN;
          OP_JZ:    w_next = ST_JZ;
          OP_JPOS:  w_next = ST_JPOS;
          OP_HALT:  w_next = ST_HALT;
        endcase
      end
      ST_LOAD, ST_STORE, ST_ADD, ST_SUB, ST_JZ, ST_JPOS: w_next = ST_FETCH;
      ST_IN:     w_next = w_enter_rise ? ST_FETCH : ST_IN;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_START;
    endcase
  end

  // Moore strobes are decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_START;
      r_pc_load   <= 1'b0;
      r_ir_load   <= 1'b0;
      r_mem_inst  <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_a_load    <= 1'b0;
      r_sub       <= 1'b0;
      r_asel      <= ASEL_ALU;
      r_halted    <= 1'b0;
      r_input_req <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pc_load   <= (w_next == ST_FETCH);
      r_ir_load   <= (w_next == ST_FETCH);
      r_mem_inst  <= (w_next inside {ST_DECODE, ST_LOAD, ST_STORE, ST_ADD, ST_SUB});
      r_mem_wr    <= (w_next == ST_STORE);
      r_a_load    <= (w_next inside {ST_LOAD, ST_ADD, ST_SUB});
      r_sub       <= (w_next == ST_SUB);
      r_asel      <= (w_next == ST_LOAD) ? ASEL_RAM : ASEL_ALU;
      r_halted    <= (w_next == ST_HALT);
      r_input_req <= (w_next == ST_IN);
    end
  end

  // Jump and IN-accept depend on same-cycle status, so they stay combinational.
  assign w_in_accept = (r_state == ST_IN) & w_enter_rise;
  assign w_take_jump = ((r_state == ST_JZ) & ctrl.Aeq0) | ((r_state == ST_JPOS) & ctrl.Apos);

  assign ctrl.PCload   = r_pc_load | w_take_jump;
  assign ctrl.JMPmux   = w_take_jump;
  assign ctrl.IRload   = r_ir_load;
  assign ctrl.Meminst  = r_mem_inst;
  assign ctrl.MemWr    = r_mem_wr;
  assign ctrl.Aload    = r_a_load | w_in_accept;
  assign ctrl.Sub      = r_sub;
  assign ctrl.Asel     = w_in_accept ? ASEL_IN : r_asel;
  assign ctrl.Halted   = r_halted;
  assign ctrl.InputReq = r_input_req;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_cpu_control_unit : random + directed bench against a phase-level model |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_cpu_control_unit;
  import cpu_control_unit_pkg::*;

  localparam int M_START = 0;
  localparam int M_FETCH = 1;
  localparam int M_DECODE = 2;
  localparam int M_EXEC = 3;
  localparam int M_HALT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int         m_stage;
  logic [2:0] m_op;
  logic       m_prev;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %b expected %b (PCld JMP IRld Mi Wr Ald Sub Asel Hlt Req)",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [10:0] dut_outs();
    return {bus.PCload, bus.JMPmux, bus.IRload, bus.Meminst, bus.MemWr, bus.Aload,
            bus.Sub, bus.Asel, bus.Halted, bus.InputReq};
  endfunction

  // Expected outputs from the instruction phase and the opcode being executed.
  function automatic logic [10:0] model_outs(input logic aeq, input logic apos, input logic en);
    logic pc, jmp, irl, mi, mw, al, sb, h, rq;
    logic [1:0] as;
    {pc, jmp, irl, mi, mw, al, sb, h, rq} = '0;
    as = 2'b00;
    case (m_stage)
      M_FETCH:  begin pc = 1; irl = 1; end
      M_DECODE: mi = 1;
      M_EXEC: begin
        case (m_op)
          3'd0: begin mi = 1; al = 1; as = 2'b10; end
          3'd1: begin mi = 1; mw = 1; end
          3'd2: begin mi = 1; al = 1; end
          3'd3: begin mi = 1; al = 1; sb = 1; end
          3'd4: begin
            rq = 1;
            if (en && !m_prev) begin al = 1; as = 2'b01; end
          end
          3'd5: if (aeq)  begin pc = 1; jmp = 1; end
          3'd6: if (apos) begin pc = 1; jmp = 1; end
          default: ;
        endcase
      end
      M_HALT:   h = 1;
      default:  ;
    endcase
    return {pc, jmp, irl, mi, mw, al, sb, as, h, rq};
  endfunction

  task automatic model_edge();
    logic rise;
    if (!rst_n) begin
      m_stage = M_START;
      m_prev  = 1'b1;
      return;
    end
    rise = bus.Enter && !m_prev;
    case (m_stage)
      M_START:  m_stage = M_FETCH;
      M_FETCH:  m_stage = M_DECODE;
      M_DECODE: begin
        m_op    = bus.IR;
        m_stage = (bus.IR == 3'd7) ? M_HALT : M_EXEC;
      end
      M_EXEC:   if (!(m_op == 3'd4 && !rise)) m_stage = M_FETCH;
      default:  ;
    endcase
    m_prev = bus.Enter;
  endtask

  task automatic step(input logic [2:0] ir, input logic aeq, input logic apos,
                      input logic en, input string tag);
    @(posedge clk);
    model_edge();
    #2;
    bus.IR = ir; bus.Aeq0 = aeq; bus.Apos = apos; bus.Enter = en;
    #2;
    check(tag, dut_outs(), model_outs(aeq, apos, en));
  endtask

  task automatic run(input logic [2:0] ir, input logic aeq, input logic apos,
                     input logic en, input int n, input string tag);
    for (int i = 0; i < n; i++) step(ir, aeq, apos, en, tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    m_stage = M_START;
    m_prev  = 1'b1;
    #1;
    check(tag, dut_outs(), 11'd0);
    step(bus.IR, bus.Aeq0, bus.Apos, bus.Enter, tag);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.IR = 3'd0; bus.Aeq0 = 1'b0; bus.Apos = 1'b0; bus.Enter = 1'b1;
    rst_n = 1'b0;
    m_stage = M_START; m_prev = 1'b1; m_op = 3'd0;
    #12;
    check("reset", dut_outs(), 11'd0);
    rst_n = 1'b1;

    run(3'd2, 0, 0, 0, 2, "pre_decode");
    async_reset("rst_mid_decode");
    run(3'd2, 0, 0, 0, 4, "add");
    run(3'd3, 0, 0, 0, 3, "sub");
    run(3'd5, 1, 0, 0, 3, "jz_taken");
    run(3'd5, 0, 1, 0, 3, "jz_not");
    run(3'd6, 0, 1, 0, 3, "jpos_taken");
    run(3'd6, 1, 0, 0, 3, "jpos_not");
    run(3'd1, 1, 1, 0, 3, "store");
    run(3'd0, 0, 0, 0, 3, "load");

    bus.Enter = 1'b1;
    async_reset("rst_enter_high");
    run(3'd4, 0, 0, 1, 8, "in_held");
    run(3'd4, 0, 0, 0, 1, "in_low");
    run(3'd4, 0, 0, 1, 2, "in_rise");
    run(3'd4, 0, 0, 1, 4, "in_stale");
    run(3'd4, 0, 0, 0, 1, "in_low2");
    run(3'd4, 0, 0, 1, 2, "in_rise2");

    run(3'd7, 0, 0, 0, 3, "halt_enter");
    for (int i = 0; i < 20; i++)
      step(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), "halt_hold");
    async_reset("rst_from_halt");
    run(3'd2, 0, 0, 0, 2, "restart");

    for (int e = 0; e < 40; e++) begin
      async_reset("rst_rand");
      for (int i = 0; i < 50; i++) begin
        logic [2:0] ir;
        ir = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        step(ir, 1'($urandom), 1'($urandom), 1'($urandom), "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
